vid_src_arbiter: RTL and testbench

//  Shares the single getbits/vld bitstream datapath between two 64-bit elementary-stream FIFOs (ch0, ch1).

---
 rtl/vid_src_arbiter.sv | 125 ++++++++++++
 tb/tb_vid_src_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vid_src_arbiter.sv
// Shares the getbits bitstream input between two elementary-stream FIFOs, with a
// drain/flush/switch sequence on request. Define ARB_WORD_COUNT_EN for per-channel word counters.
module vid_src_arbiter #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned DEFAULT_CH   = 0,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [63:0]      ch0_data,
  input  logic             ch0_empty,
  output logic             ch0_rd_en,
  input  logic [63:0]      ch1_data,
  input  logic             ch1_empty,
  output logic             ch1_rd_en,
  output logic [63:0]      vid_in,
  output logic             vid_in_empty,
  input  logic             vid_in_rd_en,
  input  logic             sw_req,
  input  logic             sw_ch,
  output logic             sw_ack,
  output logic             cur_ch,
  output logic             dec_rst,
  output logic             busy,
  output logic [CNT_W-1:0] ch0_words,
  output logic [CNT_W-1:0] ch1_words
);

  localparam logic [1:0] StRun    = 2'd0;
  localparam logic [1:0] StDrain  = 2'd1;
  localparam logic [1:0] StFlush  = 2'd2;
  localparam logic [1:0] StSwitch = 2'd3;

  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);
  localparam logic       DefCh     = 1'(DEFAULT_CH);

  logic [1:0] state_q, state_d;
  logic       cur_ch_q, cur_ch_d;
  logic       tgt_q, tgt_d;
  logic       dec_rst_q, dec_rst_d;
  logic [3:0] cnt_q, cnt_d;
  logic       run;

  always_comb begin
    state_d   = state_q;
    cur_ch_d  = cur_ch_q;
    tgt_d     = tgt_q;
    dec_rst_d = dec_rst_q;
    cnt_d     = cnt_q;
    case (state_q)
      StRun: begin
        dec_rst_d = 1'b1;
        if (sw_req) begin
          tgt_d   = sw_ch;
          state_d = StDrain;
        end
      end
      StDrain: begin
        dec_rst_d = 1'b0;
        cnt_d     = FlushLoad;
        state_d   = StFlush;
      end
      StFlush: begin
        if (cnt_q == 4'd0) begin
          cur_ch_d  = tgt_q;
          dec_rst_d = 1'b1;
          state_d   = StSwitch;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StSwitch: state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StRun;
      cur_ch_q  <= DefCh;
      tgt_q     <= DefCh;
      dec_rst_q <= 1'b0;
      cnt_q     <= 4'd0;
    end else if (clk_en) begin
      state_q   <= state_d;
      cur_ch_q  <= cur_ch_d;
      tgt_q     <= tgt_d;
      dec_rst_q <= dec_rst_d;
      cnt_q     <= cnt_d;
    end
  end

  // The mux stays on cur_ch outside RUN so the word read in the request cycle still lands.
  assign run          = (state_q == StRun);
  assign vid_in       = cur_ch_q ? ch1_data : ch0_data;
  assign vid_in_empty = run ? (cur_ch_q ? ch1_empty : ch0_empty) : 1'b1;
  assign ch0_rd_en    = run & vid_in_rd_en & ~cur_ch_q;
  assign ch1_rd_en    = run & vid_in_rd_en & cur_ch_q;
  assign sw_ack       = (state_q == StSwitch);
  assign busy         = ~run;
  assign cur_ch       = cur_ch_q;
  assign dec_rst      = dec_rst_q;

`ifdef ARB_WORD_COUNT_EN
  logic [CNT_W-1:0] ch0_words_q, ch1_words_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ch0_words_q <= '0;
      ch1_words_q <= '0;
    end else if (clk_en) begin
      if (ch0_rd_en && !ch0_empty) ch0_words_q <= ch0_words_q + CNT_W'(1);
      if (ch1_rd_en && !ch1_empty) ch1_words_q <= ch1_words_q + CNT_W'(1);
    end
  end

  assign ch0_words = ch0_words_q;
  assign ch1_words = ch1_words_q;
`else
  assign ch0_words = '0;
  assign ch1_words = '0;
`endif

endmodule

// File: tb/tb_vid_src_arbiter.sv
// Bench for vid_src_arbiter: vector table for pass-through/switch sequencing, FIFO models with a
// read-data scoreboard, and hand sequences for mid-switch reset and word counters.
module tb_vid_src_arbiter;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, clk_en;
  logic [63:0]   ch0_data = '0, ch1_data = '0;
  logic          ch0_empty, ch1_empty, ch0_rd_en, ch1_rd_en;
  logic [63:0]   vid_in;
  logic          vid_in_empty, vid_in_rd_en, sw_req, sw_ch;
  logic          sw_ack, cur_ch, dec_rst, busy;
  logic [CW-1:0] ch0_words, ch1_words;

  always #5 clk = ~clk;

  vid_src_arbiter #(
    .FLUSH_CYCLES(2),
    .DEFAULT_CH  (0),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .ch0_data    (ch0_data),
    .ch0_empty   (ch0_empty),
    .ch0_rd_en   (ch0_rd_en),
    .ch1_data    (ch1_data),
    .ch1_empty   (ch1_empty),
    .ch1_rd_en   (ch1_rd_en),
    .vid_in      (vid_in),
    .vid_in_empty(vid_in_empty),
    .vid_in_rd_en(vid_in_rd_en),
    .sw_req      (sw_req),
    .sw_ch       (sw_ch),
    .sw_ack      (sw_ack),
    .cur_ch      (cur_ch),
    .dec_rst     (dec_rst),
    .busy        (busy),
    .ch0_words   (ch0_words),
    .ch1_words   (ch1_words)
  );

  // FIFO models: first-word-fall-after-read, data valid the cycle after a non-empty read.
  logic [63:0] mem0 [64];
  logic [63:0] mem1 [64];
  int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
  assign ch0_empty = (rp0 == wp0);
  assign ch1_empty = (rp1 == wp1);

  always @(posedge clk) begin
    if (ch0_rd_en && rp0 != wp0) begin
      ch0_data <= mem0[rp0];
      rp0      <= rp0 + 1;
    end
    if (ch1_rd_en && rp1 != wp1) begin
      ch1_data <= mem1[rp1];
      rp1      <= rp1 + 1;
    end
  end

  int checks = 0, failures = 0;
  int n0 = 0, n1 = 0;
  logic [63:0] sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [63:0] e;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("vid_in", vid_in, e);
    end
  endtask

  typedef struct {
    logic rd, req, ch, en;
    logic cur, dec, bsy, ack, rd0, rd1, emp;
  } vec_t;

  function automatic vec_t mk(input logic rd, req, ch, en, cur, dec, bsy, ack, rd0, rd1, emp);
    vec_t v;
    v.rd = rd; v.req = req; v.ch = ch; v.en = en;
    v.cur = cur; v.dec = dec; v.bsy = bsy; v.ack = ack;
    v.rd0 = rd0; v.rd1 = rd1; v.emp = emp;
    return v;
  endfunction

  vec_t vt [25];
  logic [CW-1:0] exp_w0, exp_w1;

  initial begin
    //          rd req ch en  cur dec bsy ack rd0 rd1 emp
    vt[0]  = mk(1, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0);
    vt[1]  = mk(1, 0, 0, 1,  0, 1, 0, 0, 1, 0, 0);
    vt[2]  = mk(1, 0, 0, 1,  0, 1, 0, 0, 1, 0, 0);
    vt[3]  = mk(1, 1, 1, 1,  0, 1, 0, 0, 1, 0, 0);
    vt[4]  = mk(1, 0, 0, 1,  0, 1, 1, 0, 0, 0, 1);
    vt[5]  = mk(0, 0, 0, 1,  0, 0, 1, 0, 0, 0, 1);
    vt[6]  = mk(0, 1, 0, 1,  0, 0, 1, 0, 0, 0, 1);
    vt[7]  = mk(0, 0, 0, 1,  1, 1, 1, 1, 0, 0, 1);
    vt[8]  = mk(1, 0, 0, 1,  1, 1, 0, 0, 0, 1, 0);
    vt[9]  = mk(0, 0, 0, 1,  1, 1, 0, 0, 0, 0, 0);
    vt[10] = mk(0, 1, 1, 1,  1, 1, 0, 0, 0, 0, 0);
    vt[11] = mk(1, 0, 0, 1,  1, 1, 1, 0, 0, 0, 1);
    vt[12] = mk(0, 0, 0, 1,  1, 0, 1, 0, 0, 0, 1);
    vt[13] = mk(1, 0, 0, 1,  1, 0, 1, 0, 0, 0, 1);
    vt[14] = mk(0, 0, 0, 1,  1, 1, 1, 1, 0, 0, 1);
    vt[15] = mk(0, 1, 0, 1,  1, 1, 0, 0, 0, 0, 0);
    vt[16] = mk(0, 0, 0, 1,  1, 1, 1, 0, 0, 0, 1);
    vt[17] = mk(0, 0, 0, 1,  1, 0, 1, 0, 0, 0, 1);
    vt[18] = mk(0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 1);
    vt[19] = mk(0, 1, 0, 0,  1, 0, 1, 0, 0, 0, 1);
    vt[20] = mk(0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 1);
    vt[21] = mk(0, 0, 0, 1,  1, 0, 1, 0, 0, 0, 1);
    vt[22] = mk(0, 0, 0, 1,  0, 1, 1, 1, 0, 0, 1);
    vt[23] = mk(1, 0, 0, 1,  0, 1, 0, 0, 1, 0, 1);
    vt[24] = mk(0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 1);

    rst = 1'b0; clk_en = 1'b1; vid_in_rd_en = 1'b0; sw_req = 1'b0; sw_ch = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem0[i] = 64'hA000_0000_0000_0000 + 64'(i);
      mem1[i] = 64'hB000_0000_0000_0000 + 64'(i);
    end
    wp0 = 4; wp1 = 4;

    @(negedge clk);
    step();
    chk("rst_cur_ch", 64'(cur_ch), 64'd0);
    chk("rst_dec_rst", 64'(dec_rst), 64'd0);
    chk("rst_sw_ack", 64'(sw_ack), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ch1_words", 64'(ch1_words), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 25; i++) begin
      vid_in_rd_en = vt[i].rd; sw_req = vt[i].req; sw_ch = vt[i].ch; clk_en = vt[i].en;
      #1;
      chk($sformatf("v%0d_cur_ch", i), 64'(cur_ch), 64'(vt[i].cur));
      chk($sformatf("v%0d_dec_rst", i), 64'(dec_rst), 64'(vt[i].dec));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vt[i].bsy));
      chk($sformatf("v%0d_sw_ack", i), 64'(sw_ack), 64'(vt[i].ack));
      chk($sformatf("v%0d_ch0_rd_en", i), 64'(ch0_rd_en), 64'(vt[i].rd0));
      chk($sformatf("v%0d_ch1_rd_en", i), 64'(ch1_rd_en), 64'(vt[i].rd1));
      chk($sformatf("v%0d_vid_in_empty", i), 64'(vid_in_empty), 64'(vt[i].emp));
      if (vt[i].rd0 && rp0 != wp0) begin sb.push_back(mem0[rp0]); n0++; end
      if (vt[i].rd1 && rp1 != wp1) begin sb.push_back(mem1[rp1]); n1++; end
      step();
    end
    vid_in_rd_en = 1'b0; sw_req = 1'b0; clk_en = 1'b1;

    // Reset in the middle of a flush discards the pending target.
    sw_req = 1'b1; sw_ch = 1'b1;
    step();
    sw_req = 1'b0;
    step();
    chk("mid_flush_dec_rst", 64'(dec_rst), 64'd0);
    chk("mid_flush_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    step();
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_cur_ch", 64'(cur_ch), 64'd0);
    chk("mr_dec_rst", 64'(dec_rst), 64'd0);
    chk("mr_sw_ack", 64'(sw_ack), 64'd0);
    rst = 1'b1;
    step();
    chk("mr_rel_dec_rst", 64'(dec_rst), 64'd1);
    step();
    chk("mr_no_ack", 64'(sw_ack), 64'd0);
    chk("mr_cur_hold", 64'(cur_ch), 64'd0);
    exp_w0 = 0; exp_w1 = 0;
`ifdef ARB_WORD_COUNT_EN
    exp_w0 = CW'(n0);
`endif
    chk("ch0_words_after_rst", 64'(ch0_words), 64'(exp_w0));

    // Switch to ch1 and push its counter through a wrap, ending with reads of an empty FIFO.
    n0 = 0; n1 = 0;
    sw_req = 1'b1; sw_ch = 1'b1;
    step();
    sw_req = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("sw1_ack", 64'(sw_ack), 64'd1);
    chk("sw1_cur_ch", 64'(cur_ch), 64'd1);
    step();
    for (int i = 0; i < 13; i++) mem1[wp1 + i] = 64'hC000_0000_0000_0000 + 64'(i);
    wp1 = wp1 + 13;
    for (int i = 0; i < 18; i++) begin
      vid_in_rd_en = 1'b1;
      #1;
      chk("wrap_ch1_rd_en", 64'(ch1_rd_en), 64'd1);
      chk("wrap_ch0_rd_en", 64'(ch0_rd_en), 64'd0);
      if (rp1 != wp1) begin sb.push_back(mem1[rp1]); n1++; end
      step();
    end
    vid_in_rd_en = 1'b0;
    step();
`ifdef ARB_WORD_COUNT_EN
    exp_w1 = CW'(n1);
`endif
    chk("ch1_words_wrap", 64'(ch1_words), 64'(exp_w1));
    chk("ch0_words_final", 64'(ch0_words), 64'(exp_w0));
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
